// File: rtl/mul_selftest_ctrl.sv
// mul_selftest_ctrl: runs the float64 multiply checker through RUNS back-to-back
// ap_ctrl_hs invocations and reduces the returned mismatch counts to one verdict.
module mul_selftest_ctrl #(
   parameter int unsigned RUNS    = 4,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic        ap_clk,
   input  logic        ap_rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic        inconsistent,
   output logic [31:0] err_total,
   output logic [7:0]  run_count,
   output logic        dut_ap_start,
   input  logic        dut_ap_done,
   input  logic        dut_ap_idle,
   input  logic        dut_ap_ready,
   input  logic [31:0] dut_ap_return
);

   localparam logic [7:0]  RUNS_C    = 8'(RUNS);
   localparam logic [19:0] WDOG_LAST = 20'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_IDLE = 3'd1,
      S_RUN       = 3'd2,
      S_ACCUM     = 3'd3,
      S_FINISH    = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        timeout_q, timeout_d;
   logic        incons_q, incons_d;
   logic [31:0] err_total_q, err_total_d;
   logic [31:0] ret_q, ret_d;
   logic [31:0] first_q, first_d;
   logic [7:0]  run_count_q, run_count_d;
   logic [19:0] wdog_q, wdog_d;

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[32]) begin
         sat_add32 = 32'hFFFF_FFFF;
      end else begin
         sat_add32 = s[31:0];
      end
   endfunction

   // Next-state and datapath update; the verdict is formed on entry to FINISH.
   always_comb begin
      state_d     = state_q;
      pass_d      = pass_q;
      timeout_d   = timeout_q;
      incons_d    = incons_q;
      err_total_d = err_total_q;
      ret_d       = ret_q;
      first_d     = first_q;
      run_count_d = run_count_q;
      wdog_d      = wdog_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_WAIT_IDLE;
               pass_d      = 1'b0;
               timeout_d   = 1'b0;
               incons_d    = 1'b0;
               err_total_d = 32'd0;
               run_count_d = 8'd0;
               first_d     = 32'd0;
               wdog_d      = 20'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (dut_ap_idle) begin
               state_d = S_RUN;
               wdog_d  = 20'd0;
            end else if (wdog_q == WDOG_LAST) begin
               state_d   = S_FINISH;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end else begin
               wdog_d = wdog_q + 20'd1;
            end
         end
         S_RUN: begin
            // ap_ready must only ever accompany ap_done on this checker.
            if (dut_ap_ready && !dut_ap_done) begin
               incons_d = 1'b1;
            end else begin
               incons_d = incons_q;
            end
            if (dut_ap_done) begin
               state_d = S_ACCUM;
               ret_d   = dut_ap_return;
               wdog_d  = 20'd0;
            end else if (wdog_q == WDOG_LAST) begin
               state_d   = S_FINISH;
               timeout_d = 1'b1;
               pass_d    = 1'b0;
            end else begin
               wdog_d = wdog_q + 20'd1;
            end
         end
         S_ACCUM: begin
            err_total_d = sat_add32(err_total_q, ret_q);
            run_count_d = run_count_q + 8'd1;
            wdog_d      = 20'd0;
            if (run_count_q == 8'd0) begin
               first_d = ret_q;
            end else if (ret_q != first_q) begin
               incons_d = 1'b1;
            end else begin
               incons_d = incons_q;
            end
            if (run_count_d == RUNS_C) begin
               state_d = S_FINISH;
               pass_d  = (err_total_d == 32'd0) && !timeout_q && !incons_d;
            end else begin
               state_d = S_WAIT_IDLE;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_FINISH);
   end

   // State and result registers, cleared by the synchronous reset.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         incons_q    <= 1'b0;
         err_total_q <= 32'd0;
         ret_q       <= 32'd0;
         first_q     <= 32'd0;
         run_count_q <= 8'd0;
         wdog_q      <= 20'd0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         timeout_q   <= timeout_d;
         incons_q    <= incons_d;
         err_total_q <= err_total_d;
         ret_q       <= ret_d;
         first_q     <= first_d;
         run_count_q <= run_count_d;
         wdog_q      <= wdog_d;
      end
   end

   assign dut_ap_start = (state_q == S_RUN);
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign timeout      = timeout_q;
   assign inconsistent = incons_q;
   assign err_total    = err_total_q;
   assign run_count    = run_count_q;

endmodule

// File: tb/tb_mul_selftest_ctrl.sv
// Self-checking bench for mul_selftest_ctrl: a behavioural ap_ctrl_hs model of the
// multiply checker, a table of campaigns, randomized campaigns and a reset sequence.
module tb_mul_selftest_ctrl;
   localparam int RUNS_P = 3;
   localparam int TO_P   = 100;
   localparam int M_GAP  = 0;
   localparam int M_IDLE = 1;
   localparam int M_BUSY = 2;
   localparam int M_DONE = 3;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        start;
   logic        busy, done, pass, timeout, inconsistent;
   logic [31:0] err_total;
   logic [7:0]  run_count;
   logic        dut_ap_start;
   logic        dut_ap_done, dut_ap_idle, dut_ap_ready;
   logic [31:0] dut_ap_return;

   mul_selftest_ctrl #(.RUNS(RUNS_P), .TIMEOUT(TO_P)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .busy(busy), .done(done),
      .pass(pass), .timeout(timeout), .inconsistent(inconsistent),
      .err_total(err_total), .run_count(run_count), .dut_ap_start(dut_ap_start),
      .dut_ap_done(dut_ap_done), .dut_ap_idle(dut_ap_idle), .dut_ap_ready(dut_ap_ready),
      .dut_ap_return(dut_ap_return)
   );

   always #5 ap_clk = ~ap_clk;

   // Per-campaign configuration of the checker model.
   logic [31:0] cfg_ret [RUNS_P];
   int          cfg_lat [RUNS_P];
   int          cfg_gap [RUNS_P];
   bit          cfg_stray [RUNS_P];
   int          camp_id = 0;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [2:0][31:0] ret;
      int               lat [RUNS_P];
      int               gap [RUNS_P];
      bit [2:0]         stray;
      logic [31:0]      e_err;
      logic             e_pass, e_inc, e_to;
      logic [7:0]       e_rc;
   } vec_t;
   vec_t vecs [$];

   // Behavioural checker: gap cycles not idle, idle until started, lat busy cycles, one done cycle.
   int m_st, m_cnt, m_run, seen_id, m_idx;
   bit prev_start;
   initial begin
      m_st = M_IDLE; m_cnt = 0; m_run = 0; seen_id = 0; prev_start = 1'b0;
      dut_ap_idle = 1'b1; dut_ap_done = 1'b0; dut_ap_ready = 1'b0; dut_ap_return = 32'd0;
      forever begin
         @(negedge ap_clk);
         if (seen_id != camp_id) begin
            seen_id = camp_id;
            m_run   = 0;
            m_cnt   = cfg_gap[0];
            m_st    = (m_cnt > 0) ? M_GAP : M_IDLE;
         end else begin
            m_idx = (m_run < RUNS_P) ? m_run : RUNS_P - 1;
            case (m_st)
               M_GAP: begin
                  m_cnt--;
                  if (m_cnt <= 0) m_st = M_IDLE;
               end
               M_IDLE: begin
                  if (prev_start) begin
                     m_cnt = cfg_lat[m_idx];
                     m_st  = (m_cnt > 0) ? M_BUSY : M_DONE;
                  end
               end
               M_BUSY: begin
                  m_cnt--;
                  if (m_cnt <= 0) m_st = M_DONE;
               end
               default: begin
                  m_run++;
                  m_cnt = (m_run < RUNS_P) ? cfg_gap[m_run] : 0;
                  m_st  = (m_cnt > 0) ? M_GAP : M_IDLE;
               end
            endcase
         end
         m_idx         = (m_run < RUNS_P) ? m_run : RUNS_P - 1;
         dut_ap_idle   = (m_st == M_IDLE);
         dut_ap_done   = (m_st == M_DONE);
         dut_ap_ready  = (m_st == M_DONE) ||
                         (m_st == M_BUSY && cfg_stray[m_idx] && m_cnt == cfg_lat[m_idx]);
         dut_ap_return = (m_st == M_DONE) ? cfg_ret[m_idx] : 32'd0;
         prev_start    = dut_ap_start;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Campaign outcome from the rules: each run waits max(1,gap) cycles, runs lat+2 cycles, then accumulates.
   function automatic void ref_campaign(output logic [31:0] e_err, output logic e_pass,
                                        output logic e_inc, output logic e_to,
                                        output logic [7:0] e_rc, output int e_done_off,
                                        output int e_start_cyc);
      longint sum;
      int     w, r;
      bit     stop;
      sum = 0; e_inc = 1'b0; e_to = 1'b0; e_rc = 8'd0; e_done_off = 1; e_start_cyc = 0; stop = 1'b0;
      for (int i = 0; i < RUNS_P; i++) begin
         if (!stop) begin
            w = (cfg_gap[i] > 1) ? cfg_gap[i] : 1;
            r = cfg_lat[i] + 2;
            if (w > TO_P) begin
               e_done_off += TO_P; e_to = 1'b1; stop = 1'b1;
            end else begin
               e_done_off += w;
               if (cfg_stray[i] && cfg_lat[i] >= 1) e_inc = 1'b1;
               if (r > TO_P) begin
                  e_done_off += TO_P; e_start_cyc += TO_P; e_to = 1'b1; stop = 1'b1;
               end else begin
                  e_done_off += r + 1;
                  e_start_cyc += r;
                  sum += longint'({32'd0, cfg_ret[i]});
                  if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
                  if (i > 0 && cfg_ret[i] != cfg_ret[0]) e_inc = 1'b1;
                  e_rc++;
               end
            end
         end
      end
      e_err  = sum[31:0];
      e_pass = (sum == 0) && !e_to && !e_inc;
   endfunction

   task automatic run_campaign(input string tag, input logic [31:0] e_err, input logic e_pass,
                               input logic e_inc, input logic e_to, input logic [7:0] e_rc,
                               input int e_done_off, input int e_start_cyc, input int poke_off);
      int          off, done_off, done_cnt, start_cyc;
      bit          fin;
      logic [31:0] g_err;
      logic        g_pass, g_inc, g_to;
      logic [7:0]  g_rc;
      @(posedge ap_clk); #1;
      camp_id++;
      @(negedge ap_clk);
      start = 1'b1;
      off = 0; done_off = -1; done_cnt = 0; start_cyc = 0; fin = 1'b0;
      g_err = 32'd0; g_pass = 1'b0; g_inc = 1'b0; g_to = 1'b0; g_rc = 8'd0;
      while (!fin && off < 3000) begin
         @(negedge ap_clk);
         off++;
         start = (off == poke_off);
         if (off == 1) check({tag, "/busy_t1"}, busy, 1);
         if (dut_ap_start) start_cyc++;
         if (done) begin
            done_cnt++;
            if (done_off < 0) begin
               done_off = off;
               g_err = err_total; g_pass = pass; g_inc = inconsistent; g_to = timeout; g_rc = run_count;
            end
         end
         if (done_off >= 0 && off == done_off + 1) begin
            check({tag, "/busy_after"}, {busy, done}, 0);
            check({tag, "/pass_held"}, pass, g_pass);
            fin = 1'b1;
         end
      end
      if (!fin) check({tag, "/finish_bound"}, 0, 1);
      check({tag, "/err_total"}, g_err, e_err);
      check({tag, "/pass"}, g_pass, e_pass);
      check({tag, "/inconsistent"}, g_inc, e_inc);
      check({tag, "/timeout"}, g_to, e_to);
      check({tag, "/run_count"}, g_rc, e_rc);
      check({tag, "/done_cycle"}, done_off, e_done_off);
      check({tag, "/start_cycles"}, start_cyc, e_start_cyc);
      check({tag, "/done_pulses"}, done_cnt, 1);
   endtask

   task automatic add_vec(input logic [31:0] r0, r1, r2, input int l0, l1, l2, input int g0, g1, g2,
                          input bit [2:0] stray, input logic [31:0] e_err, input logic e_pass,
                          input logic e_inc, input logic e_to, input logic [7:0] e_rc);
      vec_t v;
      v.ret[0] = r0; v.ret[1] = r1; v.ret[2] = r2;
      v.lat[0] = l0; v.lat[1] = l1; v.lat[2] = l2;
      v.gap[0] = g0; v.gap[1] = g1; v.gap[2] = g2;
      v.stray = stray; v.e_err = e_err; v.e_pass = e_pass; v.e_inc = e_inc; v.e_to = e_to; v.e_rc = e_rc;
      vecs.push_back(v);
   endtask

   function automatic logic [31:0] pick_ret();
      case ($urandom_range(0, 3))
         0: pick_ret = 32'd0;
         1: pick_ret = 32'($urandom_range(1, 3));
         2: pick_ret = $urandom;
         default: pick_ret = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      endcase
   endfunction

   logic [31:0] x_err, base;
   logic        x_pass, x_inc, x_to;
   logic [7:0]  x_rc;
   int          x_done_off, x_start_cyc, cyc;

   initial begin
      //      ret0          ret1          ret2          lat0    lat1 lat2 gap0 gap1 gap2 stray  err           pass  inc   to    rc
      add_vec(32'd0,        32'd0,        32'd0,        38,     38,  38,  0,   0,   0,   3'b000, 32'd0,        1'b1, 1'b0, 1'b0, 8'd3);
      add_vec(32'd2,        32'd2,        32'd2,        38,     38,  38,  0,   0,   0,   3'b000, 32'd6,        1'b0, 1'b0, 1'b0, 8'd3);
      add_vec(32'd0,        32'd1,        32'd0,        38,     38,  38,  0,   0,   0,   3'b000, 32'd1,        1'b0, 1'b1, 1'b0, 8'd3);
      add_vec(32'd0,        32'd0,        32'd0,        100000, 0,   0,   0,   0,   0,   3'b000, 32'd0,        1'b0, 1'b0, 1'b1, 8'd0);
      add_vec(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 10,     10,  10,  0,   0,   0,   3'b000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 8'd3);
      add_vec(32'd0,        32'd0,        32'd0,        98,     98,  98,  2,   3,   1,   3'b000, 32'd0,        1'b1, 1'b0, 1'b0, 8'd3);
      add_vec(32'd5,        32'd5,        32'd5,        10,     99,  10,  0,   0,   0,   3'b000, 32'd5,        1'b0, 1'b0, 1'b1, 8'd1);
      add_vec(32'd0,        32'd0,        32'd0,        5,      5,   5,   0,   101, 0,   3'b000, 32'd0,        1'b0, 1'b0, 1'b1, 8'd1);
      add_vec(32'd0,        32'd0,        32'd0,        5,      5,   5,   0,   0,   100, 3'b000, 32'd0,        1'b1, 1'b0, 1'b0, 8'd3);
      add_vec(32'd0,        32'd0,        32'd0,        5,      5,   5,   0,   0,   0,   3'b010, 32'd0,        1'b0, 1'b1, 1'b0, 8'd3);
      add_vec(32'h80000000, 32'h80000000, 32'd1,        3,      3,   3,   0,   0,   0,   3'b000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 8'd3);
      add_vec(32'd7,        32'd7,        32'd7,        0,      0,   0,   0,   0,   0,   3'b000, 32'd21,       1'b0, 1'b0, 1'b0, 8'd3);
      add_vec(32'd4,        32'd4,        32'd4,        97,     97,  97,  100, 1,   0,   3'b000, 32'd12,       1'b0, 1'b0, 1'b0, 8'd3);

      for (int i = 0; i < RUNS_P; i++) begin
         cfg_ret[i] = 32'd0; cfg_lat[i] = 0; cfg_gap[i] = 0; cfg_stray[i] = 1'b0;
      end
      ap_rst = 1'b1;
      start  = 1'b0;
      repeat (3) @(negedge ap_clk);
      check("reset/outputs", {busy, done, pass, timeout, inconsistent, err_total, run_count, dut_ap_start}, 0);
      ap_rst = 1'b0;

      foreach (vecs[k]) begin
         for (int i = 0; i < RUNS_P; i++) begin
            cfg_ret[i] = vecs[k].ret[i]; cfg_lat[i] = vecs[k].lat[i];
            cfg_gap[i] = vecs[k].gap[i]; cfg_stray[i] = vecs[k].stray[i];
         end
         ref_campaign(x_err, x_pass, x_inc, x_to, x_rc, x_done_off, x_start_cyc);
         run_campaign($sformatf("tab%0d", k), vecs[k].e_err, vecs[k].e_pass, vecs[k].e_inc,
                      vecs[k].e_to, vecs[k].e_rc, x_done_off, x_start_cyc, 5);
      end

      for (int k = 0; k < 25; k++) begin
         base = pick_ret();
         for (int i = 0; i < RUNS_P; i++) begin
            cfg_ret[i]   = ($urandom_range(0, 2) == 0) ? pick_ret() : base;
            cfg_lat[i]   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(96, 101)) : int'($urandom_range(0, 60));
            cfg_gap[i]   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(98, 102)) : int'($urandom_range(0, 4));
            cfg_stray[i] = ($urandom_range(0, 9) == 0) && (cfg_lat[i] >= 1);
         end
         ref_campaign(x_err, x_pass, x_inc, x_to, x_rc, x_done_off, x_start_cyc);
         run_campaign($sformatf("rnd%0d", k), x_err, x_pass, x_inc, x_to, x_rc, x_done_off, x_start_cyc,
                      ($urandom_range(0, 1) == 1) ? 5 : 0);
      end

      // Reset during the second run, then a clean campaign.
      for (int i = 0; i < RUNS_P; i++) begin
         cfg_ret[i] = 32'd3; cfg_lat[i] = 30; cfg_gap[i] = 0; cfg_stray[i] = 1'b0;
      end
      @(posedge ap_clk); #1;
      camp_id++;
      @(negedge ap_clk);
      start = 1'b1;
      @(negedge ap_clk);
      start = 1'b0;
      cyc = 0;
      while (cyc < 500 && !(run_count == 8'd1 && dut_ap_start)) begin
         @(negedge ap_clk);
         cyc++;
      end
      check("rst/reached_run2", {run_count, dut_ap_start}, {8'd1, 1'b1});
      ap_rst = 1'b1;
      @(negedge ap_clk);
      check("rst/outputs", {busy, done, pass, timeout, inconsistent, err_total, run_count, dut_ap_start}, 0);
      ap_rst = 1'b0;
      for (int i = 0; i < RUNS_P; i++) cfg_ret[i] = 32'd0;
      ref_campaign(x_err, x_pass, x_inc, x_to, x_rc, x_done_off, x_start_cyc);
      run_campaign("rst/clean", 32'd0, 1'b1, 1'b0, 1'b0, 8'd3, x_done_off, x_start_cyc, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
